sseg_scan_mux: RTL



---
 rtl/sseg_scan_mux_if.sv | 30 +++
 rtl/sseg_scan_mux.sv | 120 ++++++++++++
 2 files changed

// File: rtl/sseg_scan_mux_if.sv
// Bundle of the display-side signals for sseg_scan_mux.
// The master drives value/dp/brightness/freeze; the slave returns anode and segment lines.
interface sseg_scan_mux_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    toggle;
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp;
    logic [3:0]              bright;
    logic [NUM_DIGITS-1:0]   an;
    logic [7:0]              sseg;

    modport master (
        output toggle,
        output value,
        output dp,
        output bright,
        input  an,
        input  sseg
    );

    modport slave (
        input  toggle,
        input  value,
        input  dp,
        input  bright,
        output an,
        output sseg
    );
endinterface

// File: rtl/sseg_scan_mux.sv
// Time-multiplexed common-anode seven-segment driver: prescaled digit scan, frame shadow with freeze,
// 16-level PWM brightness. Define SSEG_LZ_BLANK_EN to enable leading-zero blanking.
module sseg_scan_mux #(
    parameter int NUM_DIGITS    = 4,
    parameter int PRESCALE_LOG2 = 16
) (
    input  logic           clk,
    input  logic           reset,
    sseg_scan_mux_if.slave bus
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    logic [PRESCALE_LOG2-1:0] r_cnt;
    logic [IDX_W-1:0]         r_idx;
    logic [4*NUM_DIGITS-1:0]  r_shadow_val;
    logic [NUM_DIGITS-1:0]    r_shadow_dp;
    logic [NUM_DIGITS-1:0]    r_an;
    logic [7:0]               r_sseg;

    logic                  w_slot_end;
    logic                  w_frame_end;
    logic [3:0]            w_phase;
    logic                  w_lit;
    logic [3:0]            w_digit;
    logic                  w_dp;
    logic                  w_blank;
    logic [NUM_DIGITS-1:0] w_sel;

    function automatic logic [6:0] hex_font(input logic [3:0] d);
        case (d)
            4'h0: hex_font = 7'b0000001;
            4'h1: hex_font = 7'b1001111;
            4'h2: hex_font = 7'b0010010;
            4'h3: hex_font = 7'b0000110;
            4'h4: hex_font = 7'b1001100;
            4'h5: hex_font = 7'b0100100;
            4'h6: hex_font = 7'b0100000;
            4'h7: hex_font = 7'b0001111;
            4'h8: hex_font = 7'b0000000;
            4'h9: hex_font = 7'b0000100;
            4'hA: hex_font = 7'b0001000;
            4'hB: hex_font = 7'b1100000;
            4'hC: hex_font = 7'b0110001;
            4'hD: hex_font = 7'b1000010;
            4'hE: hex_font = 7'b0110000;
            default: hex_font = 7'b0111000;
        endcase
    endfunction

    assign w_slot_end  = (r_cnt == '1);
    assign w_frame_end = w_slot_end && (r_idx == LAST_IDX);
    // PWM phase is the top nibble of the slot counter, so each slot holds 16 equal sub-periods
    assign w_phase     = r_cnt[PRESCALE_LOG2-1 -: 4];
    assign w_lit       = (bus.bright == 4'hF) || (w_phase < bus.bright);

    always_comb begin
        w_digit = '0;
        w_dp    = 1'b0;
        w_sel   = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_sel[i] = 1'b1;
                w_digit  = r_shadow_val[4*i +: 4];
                w_dp     = r_shadow_dp[i];
            end
        end
    end

`ifdef SSEG_LZ_BLANK_EN
    logic [NUM_DIGITS-1:0] w_blank_vec;
    logic                  w_zero_above;

    // Walk from the most significant digit down; a digit is blank while everything above it is empty
    always_comb begin
        w_blank_vec  = '0;
        w_zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_zero_above   = w_zero_above && (r_shadow_val[4*i +: 4] == 4'h0) && !r_shadow_dp[i];
            w_blank_vec[i] = (i > 0) && w_zero_above;
        end
    end

    assign w_blank = |(w_blank_vec & w_sel);
`else
    assign w_blank = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_shadow_val <= '0;
            r_shadow_dp  <= '0;
            r_an         <= '1;
            r_sseg       <= 8'hFF;
        end else begin
            r_cnt <= r_cnt + 1'b1;
            if (w_slot_end) begin
                r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
            end
            if (w_frame_end && !bus.toggle) begin
                r_shadow_val <= bus.value;
                r_shadow_dp  <= bus.dp;
            end
            // Outputs are registered from the current scan state: one cycle behind cnt/idx
            if (w_lit && !w_blank) begin
                r_an   <= ~w_sel;
                r_sseg <= {~w_dp, hex_font(w_digit)};
            end else begin
                r_an   <= '1;
                r_sseg <= 8'hFF;
            end
        end
    end

    assign bus.an   = r_an;
    assign bus.sseg = r_sseg;

endmodule
